rgb_pwm_fader: RTL
==================

Name: rgb_pwm_fader

Overview:
- Parametrised multi-channel PWM generator with a per-channel fade/breathe engine; next generation of the fixed three-colour blinker.
- Sits between control logic (UART command decoder or fixed sequencer) and the SB_RGBA_DRV / SB_IO output pins.
- Duty changes are glitch-free and take effect only at PWM period boundaries.

Parameters:
- CHANNELS, 3, number of independent PWM channels.
- PWM_BITS, 8, duty and PWM counter width; period = 2^PWM_BITS ticks.
- PRESCALE_BITS, 10, PWM counter advances once every 2^PRESCALE_BITS clk cycles; 0 = every cycle.
- FADE_DIV_BITS, 4, fade/breathe step once every 2^FADE_DIV_BITS PWM periods.

Ports:
- clk  in  1  system clock (48 MHz SB_HFOSC).
- rst  in  1  synchronous, active-high reset.
- cfg_valid  in  1  configuration write request.
- cfg_ready  out  1  write accept.
- cfg_chan  in  $clog2(CHANNELS) (min 1)  target channel.
- cfg_mode  in  2  0 STATIC, 1 FADE, 2 BREATHE, 3 OFF.
- cfg_duty  in  PWM_BITS  target duty (FADE/STATIC) or breathe peak.
- pwm_out  out  CHANNELS  registered PWM outputs, active-high.
- busy  out  CHANNELS  channel ramping (duty_next != target, or BREATHE with peak > 0).
- period_start  out  1  one-cycle pulse when pwm_cnt wraps to 0.

Behaviour:
- Reset: all counters, duty_next, duty_cur, pwm_out, busy, period_start = 0; modes = STATIC; cfg_ready = 0 while rst, 1 from the first cycle after rst deasserts. Reset mid-fade clears everything on the next edge.
- Prescaler: pre_cnt free-runs; tick when pre_cnt == all-ones. pwm_cnt += 1 on tick, wraps 2^PWM_BITS-1 -> 0.
- period_start = 1 for the single cycle in which pwm_cnt holds 0 after a wrap, not during the initial post-reset count.
- Boundary latch: on period_start, duty_cur[i] <= duty_next[i].
- pwm_out[i] (registered, 1 cycle after pwm_cnt): (pwm_cnt < duty_cur[i]) or (duty_cur[i] == all-ones). Duty 0 gives constant low; all-ones gives constant high.
- Handshake: write accepted when cfg_valid & cfg_ready. cfg_chan >= CHANNELS is accepted and ignored.
- Accepted write: loads mode[i] and target[i]. STATIC/OFF set duty_next at once (OFF sets 0). FADE and BREATHE keep the current duty_next as the starting point.
- fade_tick: fade_cnt counts period_start pulses; tick on the period_start where fade_cnt wraps. The step updates duty_next in that cycle and is visible at the following boundary.
- FADE: duty_next +/- 1 toward target per fade_tick; it holds at target.
- BREATHE: duty_next triangles 0 <-> peak in steps of 1, reversing direction at 0 and at peak. If duty_next > peak on entry, it ramps down. Peak 0 holds at 0.
- Write and fade_tick to the same channel in the same cycle: the write wins and the step is dropped.
- Arithmetic never wraps: ramps saturate at 0 and all-ones.

Optional Feature:
- RGB_PWM_GAMMA_EN defined: at the boundary latch, duty_cur <= (duty_next * duty_next) >> PWM_BITS, except all-ones maps to all-ones. This is a perceptual gamma of approximately 2 and adds no latency.
- Undefined: duty_cur <= duty_next unchanged.

Decomposition:
- Package rgb_pwm_pkg holds the mode typedef (2-bit enum STATIC/FADE/BREATHE/OFF) and the mode constants.
- One sub-module, pwm_fade_chan, holds the per-channel mode, target, duty_next, duty_cur, direction, compare and busy. It is instantiated CHANNELS times via generate.
- The top keeps the prescaler, pwm_cnt, fade_cnt and config decode.

Test Plan:
All scenarios use CHANNELS=3, PWM_BITS=4, PRESCALE_BITS=0, FADE_DIV_BITS=0.
- Reset: hold rst 3 cycles mid-activity -> pwm_out=000, busy=000, cfg_ready=0. The cycle after release, cfg_ready=1.
- STATIC duty 4 on ch0 -> from the next period, pwm_out[0] is high exactly 4 of every 16 cycles. Duty 15 -> constant high. Duty 0 -> constant low.
- FADE ch1 0->3 -> duty_cur sequence 0,1,2,3 on successive periods. busy[1] falls when duty_next reaches 3. FADE back to 1 -> 3,2,1.
- BREATHE ch2 peak 2 -> duty_cur 0,1,2,1,0,1,2...; busy[2] stays 1. A peak-0 write -> holds 0 and busy[2]=0.
- Mid-period write: duty 8 -> STATIC 2 when pwm_cnt=5 -> the current period completes with 8 high cycles; the next period has 2.
- cfg_chan=3 write -> no output change. A write colliding with fade_tick -> the written target is applied and the step is dropped.

Source files
------------

// File: rtl/rgb_pwm_pkg.sv
// ---------------------------------------------------------------------------
// rgb_pwm_pkg
// Shared types for the rgb_pwm_fader block.
//   mode_t : per-channel operating mode carried by a configuration write.
//            STATIC  - duty jumps straight to the written value
//            FADE    - duty ramps by 1 per fade step toward the written value
//            BREATHE - duty triangles between 0 and the written peak
//            OFF     - duty forced to 0
// ---------------------------------------------------------------------------
package rgb_pwm_pkg;

  typedef enum logic [1:0] {
    MODE_STATIC  = 2'd0,
    MODE_FADE    = 2'd1,
    MODE_BREATHE = 2'd2,
    MODE_OFF     = 2'd3
  } mode_t;

endpackage

// File: rtl/pwm_fade_chan.sv
// ---------------------------------------------------------------------------
// pwm_fade_chan
// One PWM channel with its fade/breathe engine.
//   clk, rst      : clock, synchronous active-high reset
//   wr_en         : accepted configuration write addressed to this channel
//   wr_mode       : mode carried by the write
//   wr_duty       : target duty (STATIC/FADE) or breathe peak
//   period_start  : first cycle of a PWM period (pwm_cnt == 0 after a wrap)
//   fade_tick     : fade/breathe step strobe (coincides with period_start)
//   pwm_cnt       : shared PWM counter
//   pwm_out       : registered PWM output, active-high
//   busy          : duty still moving (or breathing with a non-zero peak)
// Optional macro RGB_PWM_GAMMA_EN: square-law gamma applied when the duty
// is latched at the period boundary.
// ---------------------------------------------------------------------------
module pwm_fade_chan
  import rgb_pwm_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  mode_t               wr_mode,
  input  logic [PWM_BITS-1:0] wr_duty,
  input  logic                period_start,
  input  logic                fade_tick,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                pwm_out,
  output logic                busy
);

  localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;
  localparam logic [PWM_BITS-1:0] DUTY_ONE = PWM_BITS'(1);

  mode_t               mode_q, mode_d;
  logic [PWM_BITS-1:0] target_q, target_d;
  logic [PWM_BITS-1:0] duty_next_q, duty_next_d;
  logic [PWM_BITS-1:0] duty_cur_q, duty_cur_d;
  logic                dir_up_q, dir_up_d;
  logic                pwm_out_q, pwm_out_d;
  logic [PWM_BITS-1:0] latch_val;
  logic [PWM_BITS-1:0] duty_eff;

`ifdef RGB_PWM_GAMMA_EN
  // Square-law curve; full scale is pinned so "always on" survives gamma.
  always_comb begin
    if (duty_next_q == DUTY_MAX) begin
      latch_val = DUTY_MAX;
    end else begin
      latch_val = PWM_BITS'(({{PWM_BITS{1'b0}}, duty_next_q} *
                             {{PWM_BITS{1'b0}}, duty_next_q}) >> PWM_BITS);
    end
  end
`else
  assign latch_val = duty_next_q;
`endif

  // In the boundary cycle duty_cur_q still holds the old period's value, so
  // the comparator uses the value being latched to keep every period whole.
  assign duty_eff = period_start ? latch_val : duty_cur_q;

  always_comb begin
    mode_d      = mode_q;
    target_d    = target_q;
    duty_next_d = duty_next_q;
    duty_cur_d  = duty_cur_q;
    dir_up_d    = dir_up_q;

    if (period_start) begin
      duty_cur_d = latch_val;
    end

    // A write takes priority over a coincident fade step, which is dropped.
    if (wr_en) begin
      mode_d = wr_mode;
      case (wr_mode)
        MODE_STATIC: begin
          target_d    = wr_duty;
          duty_next_d = wr_duty;
        end
        MODE_FADE: begin
          target_d = wr_duty;
        end
        MODE_BREATHE: begin
          target_d = wr_duty;
          dir_up_d = !(duty_next_q > wr_duty);
        end
        MODE_OFF: begin
          target_d    = '0;
          duty_next_d = '0;
        end
        default: ;
      endcase
    end else if (fade_tick) begin
      case (mode_q)
        MODE_FADE: begin
          if (duty_next_q < target_q) begin
            duty_next_d = duty_next_q + DUTY_ONE;
          end else if (duty_next_q > target_q) begin
            duty_next_d = duty_next_q - DUTY_ONE;
          end
        end
        MODE_BREATHE: begin
          // Reverse at the peak and at 0; never steps outside [0, max].
          if (dir_up_q) begin
            if (duty_next_q < target_q) begin
              duty_next_d = duty_next_q + DUTY_ONE;
            end else begin
              dir_up_d = 1'b0;
              if (duty_next_q != '0) begin
                duty_next_d = duty_next_q - DUTY_ONE;
              end
            end
          end else begin
            if (duty_next_q != '0) begin
              duty_next_d = duty_next_q - DUTY_ONE;
            end else begin
              dir_up_d = 1'b1;
              if (target_q != '0) begin
                duty_next_d = duty_next_q + DUTY_ONE;
              end
            end
          end
        end
        default: ;
      endcase
    end

    pwm_out_d = (duty_eff == DUTY_MAX) || (pwm_cnt < duty_eff);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q      <= MODE_STATIC;
      target_q    <= '0;
      duty_next_q <= '0;
      duty_cur_q  <= '0;
      dir_up_q    <= 1'b1;
      pwm_out_q   <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      target_q    <= target_d;
      duty_next_q <= duty_next_d;
      duty_cur_q  <= duty_cur_d;
      dir_up_q    <= dir_up_d;
      pwm_out_q   <= pwm_out_d;
    end
  end

  assign pwm_out = pwm_out_q;
  assign busy    = (duty_next_q != target_q) ||
                   ((mode_q == MODE_BREATHE) && (target_q != '0));

endmodule

// File: rtl/rgb_pwm_fader.sv
// ---------------------------------------------------------------------------
// rgb_pwm_fader
// Multi-channel PWM generator with per-channel fade/breathe engines.
//   clk, rst      : clock, synchronous active-high reset
//   cfg_valid     : configuration write request
//   cfg_ready     : write accept (low during reset, high afterwards)
//   cfg_chan      : target channel; out-of-range channels are accepted and
//                   ignored
//   cfg_mode      : 0 STATIC, 1 FADE, 2 BREATHE, 3 OFF
//   cfg_duty      : target duty or breathe peak
//   pwm_out       : registered PWM outputs, active-high
//   busy          : per-channel ramp-in-progress flags
//   period_start  : one-cycle pulse when pwm_cnt wraps to 0
// Optional macro RGB_PWM_GAMMA_EN enables the gamma curve in each channel.
// ---------------------------------------------------------------------------
module rgb_pwm_fader
  import rgb_pwm_pkg::*;
#(
  parameter int CHANNELS      = 3,
  parameter int PWM_BITS      = 8,
  parameter int PRESCALE_BITS = 10,
  parameter int FADE_DIV_BITS = 4,
  localparam int CHAN_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CHAN_W-1:0]   cfg_chan,
  input  logic [1:0]          cfg_mode,
  input  logic [PWM_BITS-1:0] cfg_duty,
  output logic [CHANNELS-1:0] pwm_out,
  output logic [CHANNELS-1:0] busy,
  output logic                period_start
);

  logic                tick;
  logic                fade_tick;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                period_start_q, period_start_d;
  logic                cfg_ready_q;
  logic                wr_en;

  // Prescaler: a zero-width divider degenerates to a tick every cycle.
  if (PRESCALE_BITS == 0) begin : g_no_pre
    assign tick = 1'b1;
  end else begin : g_pre
    logic [PRESCALE_BITS-1:0] pre_cnt_q, pre_cnt_d;
    always_comb pre_cnt_d = pre_cnt_q + PRESCALE_BITS'(1);
    always_ff @(posedge clk) begin
      if (rst) pre_cnt_q <= '0;
      else     pre_cnt_q <= pre_cnt_d;
    end
    assign tick = &pre_cnt_q;
  end

  // The pulse comes from the wrap itself, so the count starting at 0 out of
  // reset never raises period_start.
  always_comb begin
    pwm_cnt_d      = tick ? pwm_cnt_q + PWM_BITS'(1) : pwm_cnt_q;
    period_start_d = tick && (&pwm_cnt_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_q      <= '0;
      period_start_q <= 1'b0;
      cfg_ready_q    <= 1'b0;
    end else begin
      pwm_cnt_q      <= pwm_cnt_d;
      period_start_q <= period_start_d;
      cfg_ready_q    <= 1'b1;
    end
  end

  // Fade divider counts whole periods; the step fires on the wrapping pulse.
  if (FADE_DIV_BITS == 0) begin : g_no_fade_div
    assign fade_tick = period_start_q;
  end else begin : g_fade_div
    logic [FADE_DIV_BITS-1:0] fade_cnt_q, fade_cnt_d;
    always_comb begin
      fade_cnt_d = period_start_q ? fade_cnt_q + FADE_DIV_BITS'(1) : fade_cnt_q;
    end
    always_ff @(posedge clk) begin
      if (rst) fade_cnt_q <= '0;
      else     fade_cnt_q <= fade_cnt_d;
    end
    assign fade_tick = period_start_q && (&fade_cnt_q);
  end

  assign wr_en = cfg_valid && cfg_ready_q;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    pwm_fade_chan #(
      .PWM_BITS (PWM_BITS)
    ) u_chan (
      .clk          (clk),
      .rst          (rst),
      .wr_en        (wr_en && (cfg_chan == CHAN_W'(gi))),
      .wr_mode      (mode_t'(cfg_mode)),
      .wr_duty      (cfg_duty),
      .period_start (period_start_q),
      .fade_tick    (fade_tick),
      .pwm_cnt      (pwm_cnt_q),
      .pwm_out      (pwm_out[gi]),
      .busy         (busy[gi])
    );
  end

  assign cfg_ready    = cfg_ready_q;
  assign period_start = period_start_q;

endmodule
